alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Command-side controller that drives the 16-bit ALU (ALU16) and consumes its result and flags.
//  - Accepts one ALU command per valid/ready handshake and registers the ALU operands and opcode.
//  - Samples FinalResult, Zero, Overflow and CarryOut, then returns them on a valid/ready response port.
//  - Adds a multi-cycle MUL (shift-and-add through the ALU ADD path), so the datapath needs no separate multiplier.
// PARAMETERS
//  WIDTH   16  operand/result width; must equal the ALU width
//  CNT_W   4   step-counter width, equal to clog2(WIDTH)
// PORTS
//  Clock        in   1      single clock; all state updates on rising edge
//  ResetN       in   1      asynchronous, active-low reset
//  CmdValid     in   1      command request
//  CmdReady     out  1      controller can accept a command
//  CmdOp        in   3      command code (see package)
//  CmdA         in   WIDTH  operand A
//  CmdB         in   WIDTH  operand B
//  RspValid     out  1      response available
//  RspReady     in   1      consumer accepts the response
//  RspData      out  WIDTH  result
//  RspZero      out  1      zero flag
//  RspOverflow  out  1      signed overflow flag (MUL: product truncated)
//  RspCarry     out  1      carry-out flag
//  Busy         out  1      high in any state except IDLE
//  AluA         out  WIDTH  registered ALU operand A
//  AluB         out  WIDTH  registered ALU operand B
//  AluAInvert   out  1      registered ALU AInvert
//  AluOp        out  4      registered ALU Op
//  AluResult    in   WIDTH  ALU FinalResult
//  AluZero      in   1      ALU Zero
//  AluOverflow  in   1      ALU Overflow
//  AluCarryOut  in   1      ALU CarryOut
// BEHAVIOUR
//  Reset:
//  - State goes to IDLE. All outputs and registers clear to 0.
//  - CmdReady = 1 from the first cycle after ResetN deasserts.
//  FSM states: IDLE, ISSUE, MUL_STEP, DONE.
//  CmdReady = (IDLE) | (DONE & RspReady), so back-to-back commands are accepted with no bubble.
//  Accept (CmdValid & CmdReady) loads AluA, AluB, AluOp and AluAInvert from the command mapping.
//  - Non-MUL commands go to ISSUE.
//  - MUL goes to MUL_STEP with Acc=0, M=CmdA, Q=CmdB, cnt=0 and the sticky overflow bit cleared.
//  ISSUE (1 cycle):
//  - RspData=AluResult, RspZero=AluZero, RspOverflow=AluOverflow, RspCarry=AluCarryOut.
//  - Next state is DONE.
//  - CMP returns the subtract result and its flags unchanged.
//  MUL_STEP: ALU is driven with A=Acc, B=M, Op=ADD. Each cycle:
//  - if Q[0]: Acc<=AluResult; if AluCarryOut, set sticky overflow.
//  - if M[WIDTH-1]=1 and (Q>>1)!=0: set sticky overflow.
//  - M<=M<<1, Q<=Q>>1, cnt<=cnt+1.
//  - Exit to DONE after the step where (Q>>1)==0 or cnt==WIDTH-1. At least one step is always executed.
//  - On exit: RspData=final Acc, RspZero=(RspData==0), RspOverflow=sticky overflow, RspCarry=0.
//  Latency: RspValid rises (1+k) cycles after the accept edge.
//  - k=1 for non-MUL commands.
//  - For MUL, k = index of B's highest set bit + 1; k=1 when B=0.
//  DONE:
//  - RspValid=1. RspData and the flags are held stable until RspReady.
//  - RspReady & !CmdValid: go to IDLE and drop RspValid.
//  - RspReady & CmdValid: accept the new command in the same cycle.
//  - RspReady low: stall indefinitely, with CmdReady=0.
//  Reset asserted mid-command: the command is abandoned, no response is produced, and all outputs go to 0 asynchronously.
//  Arithmetic is modulo 2^WIDTH. The controller never computes a result itself; every result comes from the ALU.
// STRUCTURE
//  Shared package alu_pkg:
//  - CMD_AND=0, CMD_OR=1, CMD_ADD=2, CMD_SUB=3, CMD_SLT=4, CMD_NOR=5, CMD_CMP=6, CMD_MUL=7.
//  - ALU ops: ALU_AND=4'b0000, ALU_SLT=4'b0001, ALU_OR=4'b0010, ALU_ADD=4'b0100, ALU_SUB=4'b1100, ALU_NOR=4'b1000 (with AInvert=1).
//  - FSM state encoding.
//  Command mapping: CmdOp -> {AluOp, AluAInvert} as a pure function, placed in sub-module alu_cmd_decode.
//  ALU16 is instantiated by the parent. This block only drives and samples its ports.
// TESTING
//  1. ADD A=100, B=85 -> RspData=185 two cycles after accept; Z=0, V=0, C=0.
//  2. SUB A=100, B=95 -> RspData=5, C=1. CMP A=5, B=5 -> RspData=0, RspZero=1.
//  3. MUL A=300, B=200 -> RspData=60000 (0xEA60), V=0, RspValid 9 cycles after accept.
//     MUL A=256, B=256 -> RspData=0, RspZero=1, RspOverflow=1.
//  4. Hold RspReady=0 for 5 cycles -> RspValid and RspData stable, CmdReady=0.
//     Then RspReady=1 with CmdValid=1 -> new command accepted on the same edge.
//  5. Assert ResetN=0 during the 4th MUL step -> outputs go to 0 immediately and no response appears.
//     After release: CmdReady=1, and the next ADD behaves as in test 1.
//  6. Sweep all 8 CmdOp codes -> AluOp/AluAInvert match the package mapping.
//     SLT A=0xFFFF, B=1 -> RspData=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: command codes, ALU op encodings and controller FSM states shared by
// the ALU sequencing controller and its command decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_AND = 3'd0,
        CMD_OR  = 3'd1,
        CMD_ADD = 3'd2,
        CMD_SUB = 3'd3,
        CMD_SLT = 3'd4,
        CMD_NOR = 3'd5,
        CMD_CMP = 3'd6,
        CMD_MUL = 3'd7
    } cmd_e;

    // Bit 3 is the ALU's B-invert/carry-in select; NOR also needs AInvert=1.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLT = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b1100;
    localparam logic [3:0] ALU_NOR = 4'b1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MUL_STEP = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/alu_cmd_decode.sv
// alu_cmd_decode: maps a controller command code onto the ALU op and AInvert
// controls; purely combinational.
module alu_cmd_decode
    import alu_pkg::*;
(
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_op,
    output logic       a_invert
);

    always_comb begin
        alu_op   = ALU_AND;
        a_invert = 1'b0;
        case (cmd_op)
            CMD_OR:           alu_op = ALU_OR;
            CMD_ADD, CMD_MUL: alu_op = ALU_ADD;
            CMD_SUB, CMD_CMP: alu_op = ALU_SUB;
            CMD_SLT:          alu_op = ALU_SLT;
            CMD_NOR: begin
                alu_op   = ALU_NOR;
                a_invert = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command/response controller for an external 16-bit ALU, with a
// multi-cycle shift-and-add multiply that reuses the ALU's ADD path.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdA,
    input  logic [WIDTH-1:0] CmdB,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspZero,
    output logic             RspOverflow,
    output logic             RspCarry,
    output logic             Busy,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             AluAInvert,
    output logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluZero,
    input  logic             AluOverflow,
    input  logic             AluCarryOut
);

    state_e           state, state_nxt;
    logic             run;
    logic [WIDTH-1:0] acc, m, q;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [3:0]       dec_op;
    logic             dec_inv;
    logic             accept, is_mul, step_last, ovf_nxt;
    logic [WIDTH-1:0] acc_nxt, m_sh, q_sh;

    alu_cmd_decode u_decode (
        .cmd_op   (CmdOp),
        .alu_op   (dec_op),
        .a_invert (dec_inv)
    );

    // run keeps CmdReady low while reset is held and for the release cycle.
    assign CmdReady  = run & ((state == IDLE) | ((state == DONE) & RspReady));
    assign RspValid  = state == DONE;
    assign Busy      = state != IDLE;
    assign accept    = CmdValid & CmdReady;
    assign is_mul    = CmdOp == CMD_MUL;
    assign q_sh      = q >> 1;
    assign m_sh      = m << 1;
    assign acc_nxt   = q[0] ? AluResult : acc;
    assign step_last = (q_sh == '0) || (cnt == CNT_W'(WIDTH - 1));
    // Product bits lost either as an ADD carry or as a set bit shifted out of M
    // while multiplier bits remain.
    assign ovf_nxt   = ovf | (q[0] & AluCarryOut) | (m[WIDTH-1] & (q_sh != '0));

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = accept ? (is_mul ? MUL_STEP : ISSUE) : IDLE;
            ISSUE:    state_nxt = DONE;
            MUL_STEP: state_nxt = step_last ? DONE : MUL_STEP;
            DONE:     state_nxt = accept ? (is_mul ? MUL_STEP : ISSUE) : (RspReady ? IDLE : DONE);
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            run         <= 1'b0;
            acc         <= '0;
            m           <= '0;
            q           <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            AluA        <= '0;
            AluB        <= '0;
            AluOp       <= '0;
            AluAInvert  <= 1'b0;
            RspData     <= '0;
            RspZero     <= 1'b0;
            RspOverflow <= 1'b0;
            RspCarry    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                // MUL primes the ALU with Acc=0 and M=CmdA so the first step is valid at once.
                AluA       <= is_mul ? '0 : CmdA;
                AluB       <= is_mul ? CmdA : CmdB;
                AluOp      <= dec_op;
                AluAInvert <= dec_inv;
                acc        <= '0;
                m          <= CmdA;
                q          <= CmdB;
                cnt        <= '0;
                ovf        <= 1'b0;
            end else if (state == ISSUE) begin
                RspData     <= AluResult;
                RspZero     <= AluZero;
                RspOverflow <= AluOverflow;
                RspCarry    <= AluCarryOut;
            end else if (state == MUL_STEP) begin
                acc  <= acc_nxt;
                m    <= m_sh;
                q    <= q_sh;
                cnt  <= cnt + 1'b1;
                ovf  <= ovf_nxt;
                AluA <= acc_nxt;
                AluB <= m_sh;
                if (step_last) begin
                    RspData     <= acc_nxt;
                    RspZero     <= acc_nxt == '0;
                    RspOverflow <= ovf_nxt;
                    RspCarry    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl with a behavioural
// ALU16 attached to its ALU-side ports.
module tb_alu_seq_ctrl;

    typedef struct {
        logic [15:0] d;
        logic        z, v, c;
        bit          flags;
        int          lat;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b, rsp_data, alu_a, alu_b, alu_res;
    logic        rsp_zero, rsp_ovf, rsp_carry, busy, alu_inv, alu_z, alu_v, alu_c;
    logic [3:0]  alu_op;
    logic [15:0] aa, bb;
    logic [16:0] sum;
    logic [4:0]  op_map [8] = '{5'b0000_0, 5'b0010_0, 5'b0100_0, 5'b1100_0,
                                5'b0001_0, 5'b1000_1, 5'b1100_0, 5'b0100_0};
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .Clock(clk), .ResetN(rst_n),
        .CmdValid(cmd_valid), .CmdReady(cmd_ready), .CmdOp(cmd_op), .CmdA(cmd_a), .CmdB(cmd_b),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data),
        .RspZero(rsp_zero), .RspOverflow(rsp_ovf), .RspCarry(rsp_carry), .Busy(busy),
        .AluA(alu_a), .AluB(alu_b), .AluAInvert(alu_inv), .AluOp(alu_op),
        .AluResult(alu_res), .AluZero(alu_z), .AluOverflow(alu_v), .AluCarryOut(alu_c)
    );

    // ALU16 model: AInvert, B-invert with carry-in on Op[3], function on Op[2:0].
    always_comb begin
        aa  = alu_inv ? ~alu_a : alu_a;
        bb  = alu_op[3] ? ~alu_b : alu_b;
        sum = {1'b0, aa} + {1'b0, bb} + {16'd0, alu_op[3]};
        case (alu_op[2:0])
            3'b000:  alu_res = aa & bb;
            3'b010:  alu_res = aa | bb;
            3'b100:  alu_res = sum[15:0];
            3'b001:  alu_res = {15'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = 16'd0;
        endcase
        alu_c = (alu_op[2:0] == 3'b100) & sum[16];
        alu_v = (alu_op[2:0] == 3'b100) & (aa[15] == bb[15]) & (sum[15] != aa[15]);
        alu_z = alu_res == 16'd0;
    end

    function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (op)
            3'd0:       return a & b;
            3'd1:       return a | b;
            3'd2:       return a + b;
            3'd3, 3'd6: return a - b;
            3'd4:       return {15'd0, $signed(a) < $signed(b)};
            3'd5:       return ~(a | b);
            default:    return p[15:0];
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [15:0] b);
        int k = 1;
        if (op != 3'd7) return 2;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return 1 + k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic score(input int cyc);
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".lat"}, 32'(cyc), 32'(e.lat));
        check({e.tag, ".data"}, 32'(rsp_data), 32'(e.d));
        if (e.flags) begin
            check({e.tag, ".z"}, 32'(rsp_zero), 32'(e.z));
            check({e.tag, ".v"}, 32'(rsp_ovf), 32'(e.v));
            check({e.tag, ".c"}, 32'(rsp_carry), 32'(e.c));
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic z, input logic v, input logic c, input bit flags, input string tag);
        exp_t e;
        int   cyc;
        e.d = ref_res(op, a, b); e.z = z; e.v = v; e.c = c;
        e.flags = flags; e.lat = ref_lat(op, b); e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".rdy"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ".map"}, 32'({alu_op, alu_inv}), 32'(op_map[op]));
        wait_rsp(cyc);
        score(cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        bit   seen;
        exp_t e;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 16'd0; cmd_b = 16'd0; rsp_ready = 1'b1;
        #12;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.alu", 32'({alu_a, alu_b}), 32'd0);
        check("rst.rsp", 32'({rsp_data, rsp_zero, rsp_ovf, rsp_carry, alu_op, alu_inv}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.cmd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(3'd2, 16'd100, 16'd85, 1'b0, 1'b0, 1'b0, 1'b1, "add");
        run_cmd(3'd3, 16'd100, 16'd95, 1'b0, 1'b0, 1'b1, 1'b1, "sub");
        run_cmd(3'd6, 16'd5, 16'd5, 1'b1, 1'b0, 1'b1, 1'b1, "cmp");
        run_cmd(3'd7, 16'd300, 16'd200, 1'b0, 1'b0, 1'b0, 1'b1, "mul300x200");
        run_cmd(3'd7, 16'd256, 16'd256, 1'b1, 1'b1, 1'b0, 1'b1, "mul256x256");
        run_cmd(3'd7, 16'd7, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, "mul_b0");
        run_cmd(3'd4, 16'hFFFF, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, "slt");

        // Response stall followed by a same-edge accept of the next command.
        e.d = 16'd1234; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0; e.flags = 1'b1; e.lat = 2; e.tag = "stall";
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 16'd1000; cmd_b = 16'd234; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(cyc);
        score(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall.valid", 32'(rsp_valid), 32'd1);
            check("stall.data", 32'(rsp_data), 32'd1234);
            check("stall.cmd_ready", 32'(cmd_ready), 32'd0);
        end
        e.d = 16'd7; e.c = 1'b1; e.tag = "b2b";
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 16'd10; cmd_b = 16'd3; rsp_ready = 1'b1;
        #1;
        check("b2b.cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b.valid_drop", 32'(rsp_valid), 32'd0);
        check("b2b.busy", 32'(busy), 32'd1);
        wait_rsp(cyc);
        score(cyc);

        // Reset during the fourth multiply step abandons the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 16'd3; cmd_b = 16'h00F0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.ready_valid", 32'({cmd_ready, rsp_valid}), 32'd0);
        check("mid.alu", 32'({alu_a, alu_b}), 32'd0);
        check("mid.op", 32'({alu_op, alu_inv}), 32'd0);
        check("mid.rsp", 32'({rsp_data, rsp_zero, rsp_ovf, rsp_carry}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid.cmd_ready", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= rsp_valid | busy;
        end
        check("mid.no_rsp", 32'(seen), 32'd0);
        run_cmd(3'd2, 16'd100, 16'd85, 1'b0, 1'b0, 1'b0, 1'b1, "add_after_rst");

        for (int i = 0; i < 8; i++)
            run_cmd(3'(i), 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("sweep_op%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
